ingress_dispatcher: RTL and testbench
=====================================

// Module: ingress_dispatcher
// PURPOSE
//  Write-side front end for the four ingress FIFOs that the round-robin arbiter pops from.
//  Accepts one 12-bit word per cycle from a single source and reads class field data_in[11:10].
//  Pushes the word into FIFO 0..3 accordingly, honouring each FIFO's almost-full flag.
//  Words whose target FIFO stays almost-full are held, then dropped after a timeout; pushes and drops are counted.
// PARAMETERS
//  DATA_SIZE  12  word width; class field is always bits [11:10]
//  HOLD_MAX   8   max cycles a word may wait in HOLD before it is dropped (>=1)
// PORTS
//  clk           in   1          single clock, all state on posedge
//  reset         in   1          asynchronous, active-high; clears all state
//  data_in       in   DATA_SIZE  incoming word
//  valid_in      in   1          data_in valid this cycle
//  pause         in   1          1 = refuse new words (ready_out forced 0)
//  fifo_af0..3   in   1 each     almost-full of ingress FIFO 0..3
//  ready_out     out  1          1 = a word offered with valid_in is taken at this edge
//  data_out      out  DATA_SIZE  word written to the selected FIFO; 0 when no push
//  push0..3      out  1 each     registered one-hot write strobe to FIFO 0..3
//  cont0..3      out  5 each     pushes issued to FIFO 0..3; wrap 31->0
//  drop_cnt      out  8          words dropped on timeout; saturates at 255
//  state_out     out  1          0 = IDLE, 1 = HOLD (debug)
// BEHAVIOUR
//  Reset: all push*=0, data_out=0, cont*=0, drop_cnt=0, state=IDLE, hold reg/counter=0.
//    Reset is asynchronous; the outputs clear immediately on reset assertion.
//  ready_out (combinational) = (state==IDLE) & ~pause.
//  Accept = valid_in & ready_out at posedge; class c = data_in[11:10].
//  IDLE, accept, fifo_af[c]==0 at that edge:
//    next cycle push_c=1 and data_out=word (latency 1); remain IDLE.
//  IDLE, accept, fifo_af[c]==1:
//    load hold reg with the word, hold_cnt=0, go to HOLD; no push.
//  IDLE, no accept: push*=0, data_out=0.
//  HOLD, ready_out=0, per edge, checks in this order:
//    - fifo_af[c]==0: push_c=1, data_out=held word next cycle; go to IDLE.
//    - else if hold_cnt==HOLD_MAX-1: drop the word, drop_cnt+=1 (sat.), go to IDLE, no push.
//    - else hold_cnt+=1.
//  Push strobes are one-hot and last exactly one cycle per word; never two in one cycle.
//  Back-to-back: accepting a new word on the same edge that the previous word's push goes out
//    is legal; sustained throughput is 1 word/clk while no FIFO is almost-full.
//  cont_c increments on the edge after push_c is high (counts issued pushes).
//  pause: only blocks acceptance; a HOLD in progress still resolves (push or drop).
//  fifo_af is sampled at the accept/hold edge only; FIFOs must set almost-full with >=2 free slots.
//  valid_in while ready_out=0: the word is not taken; the source must keep it stable.
//  Reset mid-HOLD: the held word is discarded, no push, drop_cnt is cleared (not incremented).
// TESTING
//  1 Reset with valid_in=1 -> push*=0, data_out=0, cont*=0, drop_cnt=0; ready_out=1 after release.
//  2 Words 0x0A5,0x4A5,0x8A5,0xCA5 on consecutive clks, all af=0 -> push0..3 on clks 1..4;
//    data_out matches each word in turn; cont0..3=1 each.
//  3 fifo_af2=1, word 0x9FF -> HOLD, ready_out=0; af2 drops 3 clks later
//    -> push2 with 0x9FF on the next clk; then IDLE.
//  4 fifo_af1 stuck 1, word 0x500, HOLD_MAX=8 -> no push; drop_cnt=1 after 8 HOLD clks;
//    ready_out=1 again.
//  5 300 forced drops -> drop_cnt=255; 33 pushes to FIFO 3 -> cont3=1 (wrap).
//  6 pause=1 with valid_in=1 -> no accept, no push; assert reset during HOLD -> no push, all counters 0.

Source files
------------

// File: rtl/ingress_dispatcher.sv
// rtl/ingress_dispatcher.sv - routes one word/clk into four ingress FIFOs by class,
// holding a word while its FIFO is almost-full and dropping it after HOLD_MAX cycles.
module ingress_dispatcher #(
   parameter int DATA_SIZE = 12,
   parameter int HOLD_MAX  = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DATA_SIZE-1:0] data_in,
   input  logic                 valid_in,
   input  logic                 pause,
   input  logic                 fifo_af0,
   input  logic                 fifo_af1,
   input  logic                 fifo_af2,
   input  logic                 fifo_af3,
   output logic                 ready_out,
   output logic [DATA_SIZE-1:0] data_out,
   output logic                 push0,
   output logic                 push1,
   output logic                 push2,
   output logic                 push3,
   output logic [4:0]           cont0,
   output logic [4:0]           cont1,
   output logic [4:0]           cont2,
   output logic [4:0]           cont3,
   output logic [7:0]           drop_cnt,
   output logic                 state_out
);

   localparam int CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_MAX - 1);

   typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

   state_t               state;
   logic [DATA_SIZE-1:0] hold_reg;
   logic [CW-1:0]        hold_cnt;
   logic [3:0]           push;
   logic [4:0]           cont [4];
   logic [3:0]           af;
   logic                 accept;
   logic [1:0]           in_cls;
   logic [1:0]           hold_cls;

   assign af        = {fifo_af3, fifo_af2, fifo_af1, fifo_af0};
   assign ready_out = (state == IDLE) && !pause;
   assign accept    = valid_in && ready_out;
   assign in_cls    = data_in[DATA_SIZE-1 -: 2];
   assign hold_cls  = hold_reg[DATA_SIZE-1 -: 2];

   assign push0     = push[0];
   assign push1     = push[1];
   assign push2     = push[2];
   assign push3     = push[3];
   assign cont0     = cont[0];
   assign cont1     = cont[1];
   assign cont2     = cont[2];
   assign cont3     = cont[3];
   assign state_out = (state == HOLD);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         hold_reg <= '0;
         hold_cnt <= '0;
         push     <= 4'b0000;
         data_out <= '0;
         drop_cnt <= 8'd0;
         for (int i = 0; i < 4; i++) cont[i] <= 5'd0;
      end else begin
         push     <= 4'b0000;
         data_out <= '0;
         // Counters track strobes already on the wire, so they lag the push by one edge.
         for (int i = 0; i < 4; i++) begin
            if (push[i]) cont[i] <= cont[i] + 5'd1;
         end
         case (state)
            IDLE: begin
               if (accept) begin
                  if (!af[in_cls]) begin
                     push     <= 4'b0001 << in_cls;
                     data_out <= data_in;
                  end else begin
                     hold_reg <= data_in;
                     hold_cnt <= '0;
                     state    <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (!af[hold_cls]) begin
                  push     <= 4'b0001 << hold_cls;
                  data_out <= hold_reg;
                  hold_reg <= '0;
                  hold_cnt <= '0;
                  state    <= IDLE;
               end else if (hold_cnt == CNT_LAST) begin
                  if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
                  hold_reg <= '0;
                  hold_cnt <= '0;
                  state    <= IDLE;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ingress_dispatcher.sv
// tb/tb_ingress_dispatcher.sv - directed vector table plus hand-written hold/drop/reset sequences.
module tb_ingress_dispatcher;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [11:0] data_in = '0;
   logic        valid_in = 1'b0;
   logic        pause = 1'b0;
   logic [3:0]  af = 4'h0;
   logic        ready_out;
   logic [11:0] data_out;
   logic        push0, push1, push2, push3;
   logic [4:0]  cont0, cont1, cont2, cont3;
   logic [7:0]  drop_cnt;
   logic        state_out;
   logic [3:0]  push_v;

   int n_run  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;
   assign push_v = {push3, push2, push1, push0};

   ingress_dispatcher #(.DATA_SIZE(12), .HOLD_MAX(8)) dut (
      .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in), .pause(pause),
      .fifo_af0(af[0]), .fifo_af1(af[1]), .fifo_af2(af[2]), .fifo_af3(af[3]),
      .ready_out(ready_out), .data_out(data_out),
      .push0(push0), .push1(push1), .push2(push2), .push3(push3),
      .cont0(cont0), .cont1(cont1), .cont2(cont2), .cont3(cont3),
      .drop_cnt(drop_cnt), .state_out(state_out)
   );

   typedef struct {
      logic        v;
      logic        p;
      logic [11:0] d;
      logic [3:0]  af;
      logic        rdy;
      logic [3:0]  push;
      logic [11:0] dout;
      logic        st;
   } vec_t;

   vec_t tbl [15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic force_drop();
      data_in = 12'h500; valid_in = 1'b1; af = 4'b0010;
      @(posedge clk); #1;
      valid_in = 1'b0;
      repeat (8) @(posedge clk);
      #1;
   endtask

   initial begin
      // v, p, data, af, ready, push, data_out, state
      tbl[0]  = '{1'b1, 1'b0, 12'h0A5, 4'h0, 1'b1, 4'h1, 12'h0A5, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 12'h4A5, 4'h0, 1'b1, 4'h2, 12'h4A5, 1'b0};
      tbl[2]  = '{1'b1, 1'b0, 12'h8A5, 4'h0, 1'b1, 4'h4, 12'h8A5, 1'b0};
      tbl[3]  = '{1'b1, 1'b0, 12'hCA5, 4'h0, 1'b1, 4'h8, 12'hCA5, 1'b0};
      tbl[4]  = '{1'b0, 1'b0, 12'h000, 4'h0, 1'b1, 4'h0, 12'h000, 1'b0};
      tbl[5]  = '{1'b1, 1'b0, 12'h9FF, 4'h4, 1'b1, 4'h0, 12'h000, 1'b1};
      tbl[6]  = '{1'b0, 1'b0, 12'h000, 4'h4, 1'b0, 4'h0, 12'h000, 1'b1};
      tbl[7]  = '{1'b1, 1'b0, 12'h3AB, 4'h4, 1'b0, 4'h0, 12'h000, 1'b1};
      tbl[8]  = '{1'b0, 1'b0, 12'h000, 4'h4, 1'b0, 4'h0, 12'h000, 1'b1};
      tbl[9]  = '{1'b0, 1'b0, 12'h000, 4'h0, 1'b0, 4'h4, 12'h9FF, 1'b0};
      tbl[10] = '{1'b1, 1'b0, 12'h123, 4'h0, 1'b1, 4'h1, 12'h123, 1'b0};
      tbl[11] = '{1'b1, 1'b1, 12'h7FF, 4'h0, 1'b0, 4'h0, 12'h000, 1'b0};
      tbl[12] = '{1'b1, 1'b0, 12'h7FF, 4'h0, 1'b1, 4'h2, 12'h7FF, 1'b0};
      tbl[13] = '{1'b0, 1'b0, 12'h000, 4'h0, 1'b1, 4'h0, 12'h000, 1'b0};
      tbl[14] = '{1'b0, 1'b0, 12'h000, 4'h0, 1'b1, 4'h0, 12'h000, 1'b0};

      // Reset held with a valid word offered
      valid_in = 1'b1; data_in = 12'h0A5;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_push", push_v, 4'h0);
      chk("rst_data", data_out, 12'h000);
      chk("rst_cont", {cont3, cont2, cont1, cont0}, 20'h0);
      chk("rst_drop", drop_cnt, 8'd0);
      chk("rst_state", state_out, 1'b0);
      reset = 1'b0; valid_in = 1'b0;
      #1;
      chk("rst_ready", ready_out, 1'b1);

      for (int i = 0; i < 15; i++) begin
         valid_in = tbl[i].v; pause = tbl[i].p; data_in = tbl[i].d; af = tbl[i].af;
         #1;
         chk($sformatf("vec%0d_ready", i), ready_out, tbl[i].rdy);
         @(posedge clk); #1;
         chk($sformatf("vec%0d_push", i), push_v, tbl[i].push);
         chk($sformatf("vec%0d_data", i), data_out, tbl[i].dout);
         chk($sformatf("vec%0d_state", i), state_out, tbl[i].st);
      end
      chk("cont0_tbl", cont0, 5'd2);
      chk("cont1_tbl", cont1, 5'd2);
      chk("cont2_tbl", cont2, 5'd2);
      chk("cont3_tbl", cont3, 5'd1);

      // Stuck almost-full: word waits exactly 8 HOLD edges, then is dropped
      data_in = 12'h500; valid_in = 1'b1; af = 4'b0010;
      @(posedge clk); #1;
      valid_in = 1'b0;
      chk("drop_enter", state_out, 1'b1);
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         chk($sformatf("drop_push%0d", k), push_v, 4'h0);
         chk($sformatf("drop_state%0d", k), state_out, (k < 8) ? 1'b1 : 1'b0);
         if (k == 7) chk("drop_cnt_pre", drop_cnt, 8'd0);
      end
      chk("drop_cnt_1", drop_cnt, 8'd1);
      chk("drop_ready", ready_out, 1'b1);

      // Fresh counters: 33 back-to-back pushes to FIFO 3 wrap cont3 to 1
      reset = 1'b1; #2; reset = 1'b0;
      af = 4'h0; valid_in = 1'b1;
      for (int i = 0; i < 33; i++) begin
         data_in = 12'hC00 | 12'(i);
         @(posedge clk); #1;
         if (i == 32) chk("b2b_push_last", push_v, 4'h8);
      end
      valid_in = 1'b0;
      @(posedge clk); #1;
      chk("cont3_wrap", cont3, 5'd1);
      chk("cont0_zero", cont0, 5'd0);

      // 300 forced drops saturate drop_cnt
      for (int i = 1; i <= 300; i++) begin
         force_drop();
         if (i == 254) chk("drop_254", drop_cnt, 8'd254);
         if (i == 255) chk("drop_255", drop_cnt, 8'd255);
      end
      chk("drop_sat", drop_cnt, 8'd255);

      // Reset asserted mid-HOLD clears everything at once
      data_in = 12'h500; valid_in = 1'b1; af = 4'b0010;
      @(posedge clk); #1;
      valid_in = 1'b0;
      chk("mid_hold", state_out, 1'b1);
      #2 reset = 1'b1;
      #1;
      chk("async_state", state_out, 1'b0);
      chk("async_drop", drop_cnt, 8'd0);
      chk("async_cont3", cont3, 5'd0);
      @(posedge clk); #1;
      reset = 1'b0; af = 4'h0;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         chk($sformatf("post_rst_push%0d", k), push_v, 4'h0);
         chk($sformatf("post_rst_data%0d", k), data_out, 12'h000);
      end
      chk("post_rst_ready", ready_out, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
